// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default bit timing and 8N1 frame constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    // Line-side FSM states shared by the transmitter and the future receiver
    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

    // 50 MHz system clock / 9600 baud
    localparam int DEFAULT_CLKS_PER_BIT = 5208;

    // 8N1 framing
    localparam int UART_DATA_BITS  = 8;
    localparam int UART_START_BITS = 1;
    localparam int UART_STOP_BITS  = 1;
    localparam int UART_FRAME_BITS = UART_START_BITS + UART_DATA_BITS + UART_STOP_BITS;

    // Width of the data bit index (0..7)
    localparam int UART_IDX_W = $clog2(UART_DATA_BITS);

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle of each bit.
// Latency: bit_end is combinational, asserted during the CLKS_PER_BIT-th enabled cycle after clr.
// Backpressure: none; the timer free-runs while en is high and clr restarts it at zero.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic bit_end
);

    localparam int              CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // clr wins over en so a new frame always starts on a full bit period
    assign bit_end = en && !clr && (cnt == LAST);

    // Bit-period counter, wrapping to zero at every bit boundary
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/char_serial_tx.sv
// UART 8N1 character transmitter: start bit, 8 data bits LSB first, stop bit on tx.
// Latency: tx falls one cycle after the accepted inicio; frame lasts 10*CLKS_PER_BIT cycles, listo at its end.
// Backpressure: inicio is only honoured in IDLE; strobes while ocupado is high are dropped, never queued.
module char_serial_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      inicio,
    input  logic [UART_DATA_BITS-1:0] dato,
    output logic                      tx,
    output logic                      ocupado,
    output logic                      listo
);

    // Plain 2-bit state constants so the register can be probed with legacy tools
    localparam logic [1:0] S_IDLE  = UART_IDLE;
    localparam logic [1:0] S_START = UART_START;
    localparam logic [1:0] S_DATA  = UART_DATA;
    localparam logic [1:0] S_STOP  = UART_STOP;

    localparam logic [UART_IDX_W-1:0] LAST_IDX = UART_IDX_W'(UART_DATA_BITS - 1);

    logic [1:0]                state;
    logic [UART_DATA_BITS-1:0] shreg;
    logic [UART_IDX_W-1:0]     idx;
    logic                      frame_acc;
    logic                      bit_end;

    // A frame is accepted only from IDLE; this also restarts the bit timer
    assign frame_acc = (state == S_IDLE) && inicio;

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (frame_acc),
        .en      (state != S_IDLE),
        .bit_end (bit_end)
    );

    // Frame FSM; tx is registered and always loaded with the level of the upcoming bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            shreg   <= '0;
            idx     <= '0;
            tx      <= 1'b1;
            ocupado <= 1'b0;
            listo   <= 1'b0;
        end else begin
            listo <= 1'b0;
            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (inicio) begin
                        shreg   <= dato;
                        idx     <= '0;
                        ocupado <= 1'b1;
                        tx      <= 1'b0;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        idx   <= '0;
                        tx    <= shreg[0];
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        shreg <= shreg >> 1;
                        idx   <= idx + UART_IDX_W'(1);
                        if (idx == LAST_IDX) begin
                            tx    <= 1'b1;
                            state <= S_STOP;
                        end else begin
                            tx <= shreg[1];
                        end
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        ocupado <= 1'b0;
                        listo   <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                default: begin
                    tx      <= 1'b1;
                    ocupado <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_char_serial_tx.sv
// Self-checking bench for char_serial_tx with a frame-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_char_serial_tx;

    localparam int C = 4;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b1;
    logic       inicio  = 1'b0;
    logic [7:0] dato    = 8'h00;
    logic       tx;
    logic       ocupado;
    logic       listo;

    always #5 clk = ~clk;

    char_serial_tx #(
        .CLKS_PER_BIT (C)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .inicio  (inicio),
        .dato    (dato),
        .tx      (tx),
        .ocupado (ocupado),
        .listo   (listo)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: remembers the edge index of the accepted frame and its byte
    int         e  = 0;
    int         k  = -1;
    logic [7:0] md = 8'h00;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k = -1;
        end else begin
            e++;
            if (inicio && (k < 0 || e >= k + 10*C + 1)) begin
                k  = e;
                md = dato;
            end
        end
    end

    // Expected {tx, ocupado, listo} after the most recent edge
    function automatic logic [2:0] expect_out();
        int         t;
        logic [9:0] fr;
        if (k < 0) return 3'b100;
        t = e - k;
        if (t > 10*C) return 3'b100;
        if (t == 10*C) return 3'b101;
        fr = {1'b1, md, 1'b0};
        return {fr[t / C], 2'b10};
    endfunction

    // Per-cycle compare plus a few observed-waveform statistics
    bit         mon_en    = 1'b0;
    int         hi_run    = 0;
    int         last_run  = 0;
    int         listo_cnt = 0;
    int         ocu_cnt   = 0;
    logic [2:0] exp_o;

    always @(negedge clk) begin
        if (mon_en) begin
            exp_o = expect_out();
            check_eq("tx", tx, exp_o[2]);
            check_eq("ocupado", ocupado, exp_o[1]);
            check_eq("listo", listo, exp_o[0]);
            if (listo === 1'b1) listo_cnt++;
            if (ocupado === 1'b1) ocu_cnt++;
            if (tx === 1'b1) begin
                hi_run++;
            end else begin
                if (hi_run > 0) last_run = hi_run;
                hi_run = 0;
            end
        end
    end

    // Advance n clock edges; inputs are always driven 2 time units after the edge
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse(input logic [7:0] d);
        inicio = 1'b1;
        dato   = d;
        tick(1);
        inicio = 1'b0;
    endtask

    int l0;
    int o0;
    bit seen;

    initial begin
        // Reset with no clock edge in between
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("rst_tx", tx, 1'b1);
        check_eq("rst_ocupado", ocupado, 1'b0);
        check_eq("rst_listo", listo, 1'b0);
        mon_en = 1'b1;
        tick(2);
        reset_n = 1'b1;
        tick(2);

        // Single frame 0x41
        l0 = listo_cnt;
        o0 = ocu_cnt;
        pulse(8'h41);
        tick(45);
        check_eq("single_listo_cnt", listo_cnt - l0, 1);
        check_eq("single_ocupado_len", ocu_cnt - o0, 10*C);

        // Strobe while busy is dropped
        l0 = listo_cnt;
        pulse(8'h55);
        tick(13);
        pulse(8'hAA);
        tick(35);
        check_eq("busy_listo_cnt", listo_cnt - l0, 1);

        // Reset in the middle of a frame
        l0 = listo_cnt;
        pulse(8'hF0);
        tick(17);
        reset_n = 1'b0;
        #1;
        check_eq("midrst_tx", tx, 1'b1);
        check_eq("midrst_ocupado", ocupado, 1'b0);
        check_eq("midrst_listo", listo, 1'b0);
        tick(2);
        reset_n = 1'b1;
        tick(50);
        check_eq("midrst_no_listo", listo_cnt - l0, 0);
        l0 = listo_cnt;
        pulse(8'h96);
        tick(45);
        check_eq("after_rst_listo_cnt", listo_cnt - l0, 1);

        // Back to back with inicio held high
        l0     = listo_cnt;
        seen   = 1'b0;
        inicio = 1'b1;
        dato   = 8'h00;
        for (int i = 0; i < 120 && !seen; i++) begin
            tick(1);
            if (listo === 1'b1) begin
                dato = 8'hFF;
                seen = 1'b1;
            end
        end
        check_eq("b2b_first_listo", seen, 1'b1);
        tick(1);
        inicio = 1'b0;
        @(negedge clk);
        #1;
        check_eq("b2b_stop_len", last_run, C + 1);
        tick(45);
        check_eq("b2b_listo_cnt", listo_cnt - l0, 2);

        // Data changing every cycle after acceptance
        l0 = listo_cnt;
        pulse(8'h3C);
        for (int i = 0; i < 42; i++) begin
            dato = 8'($urandom);
            tick(1);
        end
        tick(3);
        check_eq("stable_listo_cnt", listo_cnt - l0, 1);

        // Random strobes, random data and occasional resets
        for (int i = 0; i < 2500; i++) begin
            dato   = 8'($urandom);
            inicio = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 299) == 0) begin
                reset_n = 1'b0;
                tick($urandom_range(1, 3));
                reset_n = 1'b1;
            end
            tick(1);
        end
        inicio = 1'b0;
        tick(50);
        check_eq("final_idle_ocupado", ocupado, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
